// File: rtl/gps_seq_ctrl_if.sv
// gps_seq_ctrl_if: control/status bundle between the sequencer and its host/core.
//   master: drives start/stop/config/message inputs and the core's done flag
//   slave : the sequencer; drives phase, phase-start, chip enable, message and status
interface gps_seq_if #(
  parameter int MSG_W = 32
);
  logic             start_in;
  logic             stop_in;
  logic [15:0]      cfg_ca_phase_in;
  logic             use_msg_preset_in;
  logic [MSG_W-1:0] msg_preset_in;
  logic             msg_ext_in;
  logic             code_phase_done_in;
  logic [15:0]      ca_phase_out;
  logic             ca_phase_start_out;
  logic             ena_out;
  logic             msg_out;
  logic             epoch_out;
  logic             bit_edge_out;
  logic             busy_out;
  logic [1:0]       state_out;
  modport master (
    output start_in, stop_in, cfg_ca_phase_in, use_msg_preset_in, msg_preset_in,
           msg_ext_in, code_phase_done_in,
    input  ca_phase_out, ca_phase_start_out, ena_out, msg_out, epoch_out,
           bit_edge_out, busy_out, state_out
  );
  modport slave (
    input  start_in, stop_in, cfg_ca_phase_in, use_msg_preset_in, msg_preset_in,
           msg_ext_in, code_phase_done_in,
    output ca_phase_out, ca_phase_start_out, ena_out, msg_out, epoch_out,
           bit_edge_out, busy_out, state_out
  );
endinterface

// File: rtl/gps_seq_ctrl.sv
// gps_seq_ctrl: run-time sequencer for gps_gen_core (align, chip enables, epoch/bit counting, nav bit).
//   clk_in   : system clock
//   rst_in_n : asynchronous active-low reset
//   bus      : gps_seq_if slave (start/stop/config/message in; phase, enables, msg, status out)
module gps_seq_ctrl #(
  parameter int CLK_PER_CHIP   = 16,
  parameter int CHIPS_PER_CODE = 1023,
  parameter int CODES_PER_BIT  = 20,
  parameter int MSG_W          = 32
) (
  input logic      clk_in,
  input logic      rst_in_n,
  gps_seq_if.slave bus
);
  localparam int DW = CLK_PER_CHIP   > 1 ? $clog2(CLK_PER_CHIP)   : 1;
  localparam int CW = CHIPS_PER_CODE > 1 ? $clog2(CHIPS_PER_CODE) : 1;
  localparam int KW = CODES_PER_BIT  > 1 ? $clog2(CODES_PER_BIT)  : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, ALIGN = 2'b01, RUN = 2'b10} state_t;
  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [CW-1:0]    chip_q, chip_d;
  logic [KW-1:0]    code_q, code_d;
  logic [15:0]      phase_q, phase_d;
  logic [MSG_W-1:0] word_q, word_d, word_rot;
  logic             use_q, use_d, cps_q, cps_d, ena_q, ena_d, epoch_q, epoch_d;
  logic             edge_q, edge_d, msg_q, msg_d, run_d, load_d;
  always_ff @(posedge clk_in or negedge rst_in_n)
    if (!rst_in_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      chip_q  <= '0;
      code_q  <= '0;
      phase_q <= '0;
      word_q  <= '0;
      use_q   <= 1'b0;
      cps_q   <= 1'b0;
      ena_q   <= 1'b0;
      epoch_q <= 1'b0;
      edge_q  <= 1'b0;
      msg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      chip_q  <= chip_d;
      code_q  <= code_d;
      phase_q <= phase_d;
      word_q  <= word_d;
      use_q   <= use_d;
      cps_q   <= cps_d;
      ena_q   <= ena_d;
      epoch_q <= epoch_d;
      edge_q  <= edge_d;
      msg_q   <= msg_d;
    end
  always_comb begin
    state_d = state_q == IDLE ? ((bus.start_in && !bus.stop_in) ? ALIGN : IDLE) :
              bus.stop_in ? IDLE :
              (state_q == ALIGN && bus.code_phase_done_in) ? RUN :
              (state_q == ALIGN || state_q == RUN) ? state_q : IDLE;
  end
  // Every output is registered, so each pulse is decided from the next-cycle
  // counter values; leaving RUN clears everything and drops scheduled pulses.
  always_comb begin
    run_d    = state_d == RUN;
    load_d   = state_q == IDLE && state_d == ALIGN;
    word_rot = (word_q << 1) | (word_q >> (MSG_W - 1));
    div_d    = (run_d && state_q == RUN && div_q != DW'(CLK_PER_CHIP - 1)) ? div_q + DW'(1) : '0;
    chip_d   = !run_d ? '0 : !ena_q ? chip_q :
               chip_q == CW'(CHIPS_PER_CODE - 1) ? '0 : chip_q + CW'(1);
    code_d   = !run_d ? '0 : !epoch_q ? code_q :
               code_q == KW'(CODES_PER_BIT - 1) ? '0 : code_q + KW'(1);
    ena_d    = run_d && div_d == DW'(CLK_PER_CHIP - 1);
    epoch_d  = ena_d && chip_d == CW'(CHIPS_PER_CODE - 1);
    edge_d   = epoch_d && code_d == KW'(CODES_PER_BIT - 1);
    cps_d    = state_d == ALIGN;
    phase_d  = load_d ? bus.cfg_ca_phase_in : phase_q;
    use_d    = load_d ? bus.use_msg_preset_in : use_q;
    word_d   = load_d ? bus.msg_preset_in : (state_q == RUN && edge_q) ? word_rot : word_q;
    // First RUN cycle shows the first bit; afterwards the bit moves only in the
    // cycle following a bit-edge pulse.
    msg_d    = !run_d ? 1'b0 :
               state_q != RUN ? (use_q ? word_q[MSG_W-1] : bus.msg_ext_in) :
               edge_q ? (use_q ? word_rot[MSG_W-1] : bus.msg_ext_in) : msg_q;
  end
  assign bus.ca_phase_out       = phase_q;
  assign bus.ca_phase_start_out = cps_q;
  assign bus.ena_out            = ena_q;
  assign bus.msg_out            = msg_q;
  assign bus.epoch_out          = epoch_q;
  assign bus.bit_edge_out       = edge_q;
  assign bus.busy_out           = state_q != IDLE;
  assign bus.state_out          = state_q;
endmodule

// File: tb/tb_gps_seq_ctrl.sv
// tb_gps_seq_ctrl: scoreboard bench for gps_seq_ctrl with a timing-level reference model.
module tb_gps_seq_ctrl;
  localparam int CPC = 4, CPS = 8, CPB = 3, MW = 8, BL = CPC * CPS * CPB;
  typedef struct {int cyc; logic [23:0] v;} rec_t;
  logic clk_in = 1'b0, rst_in_n = 1'b0;
  int cyc = 0, n_cmp = 0, n_bad = 0, align_cnt = 0;
  rec_t q[$];
  gps_seq_if #(.MSG_W(MW)) bus();
  gps_seq_ctrl #(.CLK_PER_CHIP(CPC), .CHIPS_PER_CODE(CPS), .CODES_PER_BIT(CPB), .MSG_W(MW))
    dut (.clk_in(clk_in), .rst_in_n(rst_in_n), .bus(bus));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  // core model: counts ALIGN cycles, done once the count reaches the phase
  always @(posedge clk_in or negedge rst_in_n)
    align_cnt <= !rst_in_n ? 0 : (bus.ca_phase_start_out && !bus.ena_out) ? align_cnt + 1 : 0;
  assign bus.code_phase_done_in = bus.ca_phase_start_out && align_cnt == int'(bus.ca_phase_out);
  function automatic logic [23:0] act();
    return {bus.state_out, bus.busy_out, bus.ca_phase_start_out, bus.ena_out, bus.epoch_out,
            bus.bit_edge_out, bus.msg_out, bus.ca_phase_out};
  endfunction
  function automatic logic [23:0] pack(logic [1:0] st, logic cps, logic ena, logic ep,
                                       logic be, logic m, logic [15:0] ph);
    return {st, |st, cps, ena, ep, be, m, ph};
  endfunction
  task automatic check(string nm, logic [23:0] a, logic [23:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  always @(negedge clk_in) if (rst_in_n) begin
    rec_t r;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      r = q.pop_front();
      check($sformatf("cyc%0d", r.cyc), act(), r.v);
    end else
      check($sformatf("idle%0d", cyc), {act() & 24'hFF0000}, 24'h0);
  end
  // One start..stop session; expectations for every cycle are queued up front.
  task automatic session(int phase, bit usep, logic [MW-1:0] pre, int runc, bit hold, int rst_at);
    int c0, e, len, t, b;
    logic ena, ep, be, m;
    logic ext[];
    rec_t r;
    c0 = cyc;
    e = c0 + 2 + phase;
    len = e + runc - c0;
    ext = new[len + 1];
    foreach (ext[k]) ext[k] = 1'($urandom);
    for (int i = c0 + 1; i <= e + runc; i++) begin
      r.cyc = i;
      t = i - e;
      if (i < e) r.v = pack(2'b01, 1, 0, 0, 0, 0, 16'(phase));
      else if (t == runc) r.v = pack(2'b00, 0, 0, 0, 0, 0, 16'(phase));
      else begin
        b = t / BL;
        ena = t % CPC == CPC - 1;
        ep = ena && (t / CPC) % CPS == CPS - 1;
        be = ep && (t / (CPC * CPS)) % CPB == CPB - 1;
        m = usep ? pre[MW - 1 - b % MW] : ext[e - 1 + b * BL - c0];
        r.v = pack(2'b10, 0, ena, ep, be, m, 16'(phase));
      end
      q.push_back(r);
    end
    for (int k = 0; k <= len; k++) begin
      bus.start_in = k == 0 || (hold && k < len);
      bus.stop_in = k == len - 1;
      bus.cfg_ca_phase_in = k == 0 ? 16'(phase) : 16'($urandom);
      bus.use_msg_preset_in = k == 0 ? usep : 1'($urandom);
      bus.msg_preset_in = k == 0 ? pre : MW'($urandom);
      bus.msg_ext_in = ext[k];
      if (rst_at != 0 && k == rst_at) begin
        bus.start_in = 0;
        bus.stop_in = 0;
        #2 rst_in_n = 0;
        q.delete();
        #1 check("async_rst", act(), 24'h0);
        repeat (2) @(posedge clk_in);
        #1 rst_in_n = 1;
        return;
      end
      @(posedge clk_in);
      #1;
    end
    bus.start_in = 0;
    bus.stop_in = 0;
  endtask
  initial begin
    bus.start_in = 0;
    bus.stop_in = 0;
    bus.cfg_ca_phase_in = 0;
    bus.use_msg_preset_in = 0;
    bus.msg_preset_in = 0;
    bus.msg_ext_in = 0;
    #12 check("reset", act(), 24'h0);
    @(posedge clk_in);
    #1 rst_in_n = 1;
    repeat (3) @(posedge clk_in);
    #1;
    session(5, 1, 8'hA5, 200, 0, 0);
    session(0, 1, 8'hA5, BL * 9, 1, 0);
    session(3, 0, 8'h00, BL * 4, 0, 0);
    session(7, 1, 8'h5A, 31, 0, 0);
    session(2, 0, 8'h00, BL - 1, 1, 0);
    bus.start_in = 1;
    bus.stop_in = 1;
    repeat (5) @(posedge clk_in);
    #1;
    bus.start_in = 0;
    bus.stop_in = 0;
    repeat (4) session($urandom_range(0, 9), 1'($urandom), MW'($urandom),
                       $urandom_range(1, 300), 1'($urandom), 0);
    session(4, 1, 8'h3C, 150, 0, 60);
    repeat (4) @(posedge clk_in);
    #1 check("post_rst", act(), 24'h0);
    session(1, 0, 8'h00, 100, 0, 0);
    repeat (5) @(posedge clk_in);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
